lcd_timing_gen: RTL and testbench
=================================

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 1, hsync pulse width in pixels.
REQ-002 SHALL have parameter H_BP, default 182, horizontal back porch in pixels.
REQ-003 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-004 SHALL have parameter H_FP, default 210, horizontal front porch in pixels.
REQ-005 SHALL have parameters V_SYNC 5, V_BP 0, V_ACTIVE 480, V_FP 45, the vertical equivalents in lines.
REQ-006 SHALL have parameters HS_POL 0, VS_POL 0, DE_POL 1, each giving the asserted level of its sync/DE output.
REQ-007 SHALL have parameter CW, default 12, counter and coordinate width in bits.
REQ-008 PixelClk  in  1  sole clock; all logic on its rising edge.
REQ-009 RST  in  1  synchronous, active-high reset.
REQ-010 EN  in  1  run enable; low holds the generator in idle.
REQ-011 MODE  in  2  pattern select: 0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid.
REQ-012 SOLID_RGB  in  16  RGB565 colour for mode 3.
REQ-013 LCD_HSYNC, LCD_VSYNC, LCD_DE  out  1 each  registered timing outputs.
REQ-014 LCD_R  out  5;  LCD_G  out  6;  LCD_B  out  5  registered pixel data.
REQ-015 PIX_X, PIX_Y  out  CW each  active-area coordinate of the current output pixel.
REQ-016 FRAME_START, LINE_START  out  1 each  single-cycle strobes.

Function
REQ-017 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP; h_cnt SHALL run 0..H_TOTAL-1 and wrap to 0.
REQ-018 v_cnt SHALL increment only when h_cnt == H_TOTAL-1 and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-019 hsync SHALL be asserted for h_cnt < H_SYNC; vsync SHALL be asserted for v_cnt < V_SYNC.
REQ-020 Active: H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE; DE SHALL be asserted exactly there.
REQ-021 All outputs SHALL be registered with one cycle of latency from the counters and mutually aligned.
REQ-022 Outside the active area LCD_R/G/B SHALL be 0 and PIX_X/PIX_Y SHALL hold 0.
REQ-023 Inside the active area, x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP); these SHALL drive PIX_X/PIX_Y.
REQ-024 FRAME_START SHALL pulse with the output for h_cnt=0, v_cnt=0.
REQ-025 LINE_START SHALL pulse with the output for every h_cnt=0.
REQ-026 MODE and SOLID_RGB SHALL be latched only when the counters are at h_cnt=0, v_cnt=0; mid-frame changes take effect next frame.
REQ-027 Mode 0 SHALL generate 8 bars of width H_ACTIVE/8, ordered white, yellow, cyan, green, magenta, red, blue, black; any remainder pixels are black.
REQ-028 Mode 1 SHALL output R=x[8:4], G=x[8:3], B=x[8:4] (grey ramp repeating every 512 px).
REQ-029 Mode 2 SHALL output white (all ones) when x[5]^y[5] is 1, else black.
REQ-030 Mode 3 SHALL output the latched SOLID_RGB: R=[15:11], G=[10:5], B=[4:0].
REQ-031 With EN low, the counters SHALL be held at 0 and all outputs SHALL be at their reset values.
REQ-032 On EN rising, the generator SHALL start at h_cnt=0, v_cnt=0; FRAME_START SHALL follow one cycle later.
REQ-033 Sync/DE output level = asserted ? POL : ~POL for each of HS_POL, VS_POL and DE_POL.

Reset
REQ-034 On RST, counters SHALL clear; hsync, vsync and DE SHALL be deasserted (~POL levels); R/G/B, PIX_X, PIX_Y and strobes SHALL be 0; the latched mode SHALL be 0.
REQ-035 RST SHALL dominate EN; RST mid-frame SHALL abort the frame, and the first cycle after release SHALL count h_cnt=0, v_cnt=0.

Verification (params H 2/3/16/4, V 1/1/4/2, so H_TOTAL=25, V_TOTAL=8)
REQ-036 Release RST with EN=1 -> FRAME_START high on cycle 1; hsync low for cycles 1-2; frame period 200 cycles; LINE_START every 25 cycles.
REQ-037 Mode 0 -> DE first high in line v_cnt=2 at output h_cnt=5; bars 2 px wide; RGB 1F/3F/1F for x=0-1, 1F/3F/00 for x=2-3; black for x=14-15.
REQ-038 MODE set 0->3 mid-frame with SOLID_RGB=F800 -> current frame stays bars; next frame is R=1F, G=0, B=0.
REQ-039 EN dropped mid-line -> next cycle outputs idle (DE deasserted, RGB 0); EN reasserted -> FRAME_START after one cycle.
REQ-040 HS_POL=1, DE_POL=0 -> hsync high for 2 cycles per line; DE low exactly over the 16x4 active window.
REQ-041 Mode 2 with H_ACTIVE=64, V_ACTIVE=64 -> pixel (31,0) white-free (black), (32,0) white, (32,32) black.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator with built-in test patterns; every output is registered
// one cycle behind the h/v counters. EN low or RST parks the raster at the origin, outputs idle.
module lcd_timing_gen #(
    parameter int   H_SYNC   = 1,
    parameter int   H_BP     = 182,
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 210,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 0,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 45,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter logic DE_POL   = 1'b1,
    parameter int   CW       = 12
) (
    input  logic          PixelClk,
    input  logic          RST,
    input  logic          EN,
    input  logic [1:0]    MODE,
    input  logic [15:0]   SOLID_RGB,
    output logic          LCD_HSYNC,
    output logic          LCD_VSYNC,
    output logic          LCD_DE,
    output logic [4:0]    LCD_R,
    output logic [5:0]    LCD_G,
    output logic [4:0]    LCD_B,
    output logic [CW-1:0] PIX_X,
    output logic [CW-1:0] PIX_Y,
    output logic          FRAME_START,
    output logic          LINE_START
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    // Pattern maths reads x[8:3] and y[5], so widen narrow coordinates.
    localparam int XW      = (CW > 9) ? CW : 9;

    localparam logic [CW-1:0] C_H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_H_SYNC = CW'(H_SYNC);
    localparam logic [CW-1:0] C_V_SYNC = CW'(V_SYNC);
    localparam logic [CW-1:0] C_H_AS   = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] C_H_AE   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] C_V_AS   = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] C_V_AE   = CW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CW-1:0] C_BAR_W  = CW'(BAR_W);

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic [1:0]    r_mode;
    logic [15:0]   r_solid;

    logic          w_origin;
    logic          w_line0;
    logic          w_hs;
    logic          w_vs;
    logic          w_act;
    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic [XW-1:0] w_xe;
    logic [XW-1:0] w_ye;
    logic [CW-1:0] w_bar;
    logic [1:0]    w_mode;
    logic [15:0]   w_solid;
    logic [4:0]    w_r;
    logic [5:0]    w_g;
    logic [4:0]    w_b;

    assign w_line0  = (r_h_cnt == '0);
    assign w_origin = w_line0 && (r_v_cnt == '0);
    assign w_hs     = (r_h_cnt < C_H_SYNC);
    assign w_vs     = (r_v_cnt < C_V_SYNC);
    assign w_act    = (r_h_cnt >= C_H_AS) && (r_h_cnt < C_H_AE) &&
                      (r_v_cnt >= C_V_AS) && (r_v_cnt < C_V_AE);
    assign w_x      = w_act ? (r_h_cnt - C_H_AS) : '0;
    assign w_y      = w_act ? (r_v_cnt - C_V_AS) : '0;
    assign w_xe     = XW'(w_x);
    assign w_ye     = XW'(w_y);
    assign w_bar    = w_x / C_BAR_W;

    // The origin pixel is the one that latches MODE, so it already sees the new value.
    assign w_mode   = w_origin ? MODE      : r_mode;
    assign w_solid  = w_origin ? SOLID_RGB : r_solid;

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_act) begin
            case (w_mode)
                2'd0: begin
                    // Bar index bits map straight to inverted R/G/B enables.
                    if (w_bar < CW'(8)) begin
                        w_r = {5{~w_bar[1]}};
                        w_g = {6{~w_bar[2]}};
                        w_b = {5{~w_bar[0]}};
                    end
                end
                2'd1: begin
                    w_r = w_xe[8:4];
                    w_g = w_xe[8:3];
                    w_b = w_xe[8:4];
                end
                2'd2: begin
                    if (w_xe[5] ^ w_ye[5]) begin
                        w_r = '1;
                        w_g = '1;
                        w_b = '1;
                    end
                end
                default: begin
                    w_r = w_solid[15:11];
                    w_g = w_solid[10:5];
                    w_b = w_solid[4:0];
                end
            endcase
        end
    end

    always_ff @(posedge PixelClk) begin
        if (RST || !EN) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            if (RST) begin
                r_mode  <= '0;
                r_solid <= '0;
            end
            LCD_HSYNC   <= ~HS_POL;
            LCD_VSYNC   <= ~VS_POL;
            LCD_DE      <= ~DE_POL;
            LCD_R       <= '0;
            LCD_G       <= '0;
            LCD_B       <= '0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            FRAME_START <= 1'b0;
            LINE_START  <= 1'b0;
        end else begin
            if (r_h_cnt == C_H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
            if (w_origin) begin
                r_mode  <= MODE;
                r_solid <= SOLID_RGB;
            end
            LCD_HSYNC   <= w_hs  ? HS_POL : ~HS_POL;
            LCD_VSYNC   <= w_vs  ? VS_POL : ~VS_POL;
            LCD_DE      <= w_act ? DE_POL : ~DE_POL;
            LCD_R       <= w_r;
            LCD_G       <= w_g;
            LCD_B       <= w_b;
            PIX_X       <= w_x;
            PIX_Y       <= w_y;
            FRAME_START <= w_origin;
            LINE_START  <= w_line0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench: three generator instances (reference timing, inverted polarities, 64x64 checker).
// Stimulus queues timed expectations; a negedge monitor pops and compares them.
module tb_lcd_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] solid;

    logic        hs [3];
    logic        vs [3];
    logic        de [3];
    logic [4:0]  r  [3];
    logic [5:0]  g  [3];
    logic [4:0]  b  [3];
    logic [11:0] px [3];
    logic [11:0] py [3];
    logic        fs [3];
    logic        ls [3];

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(16), .H_FP(4),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4),  .V_FP(2)
    ) u_dut0 (
        .PixelClk(clk), .RST(rst), .EN(en), .MODE(mode), .SOLID_RGB(solid),
        .LCD_HSYNC(hs[0]), .LCD_VSYNC(vs[0]), .LCD_DE(de[0]),
        .LCD_R(r[0]), .LCD_G(g[0]), .LCD_B(b[0]),
        .PIX_X(px[0]), .PIX_Y(py[0]), .FRAME_START(fs[0]), .LINE_START(ls[0])
    );

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(16), .H_FP(4),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4),  .V_FP(2),
        .HS_POL(1'b1), .DE_POL(1'b0)
    ) u_dut1 (
        .PixelClk(clk), .RST(rst), .EN(en), .MODE(mode), .SOLID_RGB(solid),
        .LCD_HSYNC(hs[1]), .LCD_VSYNC(vs[1]), .LCD_DE(de[1]),
        .LCD_R(r[1]), .LCD_G(g[1]), .LCD_B(b[1]),
        .PIX_X(px[1]), .PIX_Y(py[1]), .FRAME_START(fs[1]), .LINE_START(ls[1])
    );

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(64), .H_FP(4),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(64), .V_FP(2)
    ) u_dut2 (
        .PixelClk(clk), .RST(rst), .EN(en), .MODE(2'd2), .SOLID_RGB(16'h0000),
        .LCD_HSYNC(hs[2]), .LCD_VSYNC(vs[2]), .LCD_DE(de[2]),
        .LCD_R(r[2]), .LCD_G(g[2]), .LCD_B(b[2]),
        .PIX_X(px[2]), .PIX_Y(py[2]), .FRAME_START(fs[2]), .LINE_START(ls[2])
    );

    localparam int HS = 0, VS = 1, DE = 2, RR = 3, GG = 4, BB = 5, PX = 6, PY = 7, FS = 8, LS = 9;
    string names [10] = '{"HSYNC", "VSYNC", "DE", "R", "G", "B", "PIX_X", "PIX_Y", "FRAME_START", "LINE_START"};

    typedef struct {
        int t;
        int d;
        int s;
        int v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   ac = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) ac <= ac + 1;

    function automatic logic [15:0] sig_of(int d, int s);
        case (s)
            HS:      return {15'd0, hs[d]};
            VS:      return {15'd0, vs[d]};
            DE:      return {15'd0, de[d]};
            RR:      return {11'd0, r[d]};
            GG:      return {10'd0, g[d]};
            BB:      return {11'd0, b[d]};
            PX:      return {4'd0, px[d]};
            PY:      return {4'd0, py[d]};
            FS:      return {15'd0, fs[d]};
            default: return {15'd0, ls[d]};
        endcase
    endfunction

    task automatic push_abs(int t, int d, int s, int v);
        exp_t x;
        int   i = 0;
        x.t = t; x.d = d; x.s = s; x.v = v;
        while (i < q.size() && q[i].t <= t) i++;
        q.insert(i, x);
    endtask

    task automatic push(int n, int d, int s, int v);
        push_abs(base + n, d, s, v);
    endtask

    task automatic wait_to(int n);
        while (ac < base + n) @(negedge clk);
    endtask

    // Monitor: drains every expectation due at this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].t <= ac) begin
            e = q.pop_front();
            checks++;
            if (e.t < ac) begin
                errors++;
                $display("FAIL dut%0d %s: check due at cycle %0d was skipped (now %0d)",
                         e.d, names[e.s], e.t, ac);
            end else if (sig_of(e.d, e.s) !== 16'(e.v)) begin
                errors++;
                $display("FAIL dut%0d %s @cycle %0d: got 0x%0h, expected 0x%0h",
                         e.d, names[e.s], e.t, sig_of(e.d, e.s), e.v);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'd0; solid = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset state
        push_abs(ac + 1, 0, HS, 1); push_abs(ac + 1, 0, VS, 1); push_abs(ac + 1, 0, DE, 0);
        push_abs(ac + 1, 0, RR, 0); push_abs(ac + 1, 0, GG, 0); push_abs(ac + 1, 0, BB, 0);
        push_abs(ac + 1, 0, PX, 0); push_abs(ac + 1, 0, PY, 0);
        push_abs(ac + 1, 0, FS, 0); push_abs(ac + 1, 0, LS, 0);
        push_abs(ac + 1, 1, HS, 0); push_abs(ac + 1, 1, DE, 1); push_abs(ac + 1, 2, DE, 0);
        repeat (2) @(negedge clk);

        // Phase 1: first frame of bars, mode change, EN drop
        rst = 1'b0;
        base = ac;
        push(1, 0, FS, 1); push(1, 0, LS, 1); push(1, 0, HS, 0); push(1, 0, VS, 0); push(1, 1, HS, 1);
        push(2, 0, HS, 0); push(2, 0, FS, 0); push(2, 1, HS, 1);
        push(3, 0, HS, 1); push(3, 1, HS, 0);
        push(26, 0, LS, 1); push(26, 0, FS, 0); push(26, 0, VS, 1);
        push(55, 0, DE, 0); push(55, 1, DE, 1);
        push(56, 0, DE, 1); push(56, 0, RR, 5'h1F); push(56, 0, GG, 6'h3F); push(56, 0, BB, 5'h1F);
        push(56, 0, PX, 0); push(56, 0, PY, 0); push(56, 1, DE, 0);
        push(58, 0, RR, 5'h1F); push(58, 0, GG, 6'h3F); push(58, 0, BB, 0); push(58, 0, PX, 2);
        push(64, 0, RR, 5'h1F); push(64, 0, GG, 0); push(64, 0, BB, 5'h1F);
        push(70, 0, DE, 1); push(70, 0, RR, 0); push(70, 0, GG, 0); push(70, 0, BB, 0);
        push(72, 0, DE, 0); push(72, 0, RR, 0); push(72, 0, PX, 0); push(72, 1, DE, 1);
        push(84, 0, PX, 3); push(84, 0, PY, 1);
        push(146, 0, DE, 1); push(146, 0, PX, 15); push(146, 0, PY, 3); push(146, 1, DE, 0);
        push(147, 0, DE, 0); push(147, 0, PY, 0);
        push(156, 0, DE, 0); push(156, 1, DE, 1);
        push(176, 0, LS, 1); push(177, 0, LS, 0);
        push(183, 2, DE, 1); push(183, 2, RR, 0); push(183, 2, PX, 31);
        push(184, 2, RR, 5'h1F); push(184, 2, GG, 6'h3F); push(184, 2, BB, 5'h1F); push(184, 2, PX, 32);
        push(200, 0, FS, 0); push(201, 0, FS, 1); push(201, 0, VS, 0);
        push(256, 0, DE, 1); push(256, 0, RR, 5'h1F); push(256, 0, GG, 0); push(256, 0, BB, 0);
        push(258, 0, RR, 5'h1F); push(258, 0, GG, 0); push(258, 0, BB, 0);
        push(261, 0, DE, 0); push(261, 0, RR, 0); push(261, 0, HS, 1); push(261, 0, FS, 0);
        push(261, 0, LS, 0); push(261, 1, HS, 0); push(261, 1, DE, 1);
        push(265, 0, FS, 0); push(265, 0, DE, 0);

        wait_to(10);
        mode = 2'd3; solid = 16'hF800;
        wait_to(260);
        en = 1'b0;
        wait_to(265);
        en = 1'b1;

        // Phase 2: restart after EN, then abort with RST mid-line
        base = ac;
        push(1, 0, FS, 1); push(1, 0, LS, 1); push(1, 0, HS, 0);
        push(56, 0, DE, 1); push(56, 0, RR, 5'h1F); push(56, 0, GG, 0); push(56, 0, BB, 0);
        push(56, 1, DE, 0);
        push(60, 0, DE, 1);
        push(61, 0, DE, 0); push(61, 0, RR, 0); push(61, 0, HS, 1); push(61, 0, VS, 1);
        push(61, 0, PX, 0); push(61, 0, FS, 0); push(61, 1, HS, 0); push(61, 1, DE, 1);
        wait_to(60);
        rst = 1'b1; mode = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Phase 3: clean frame after reset, long run for the 64x64 checker
        base = ac;
        push(1, 0, FS, 1); push(1, 0, LS, 1); push(25, 0, LS, 0); push(26, 0, LS, 1);
        push(56, 0, DE, 1); push(56, 0, RR, 5'h1F); push(56, 0, GG, 6'h3F); push(56, 0, BB, 5'h1F);
        push(56, 0, PX, 0);
        push(58, 0, BB, 0);
        push(183, 2, RR, 0); push(184, 2, RR, 5'h1F);
        push(2488, 2, RR, 5'h1F); push(2488, 2, PX, 0); push(2488, 2, PY, 32);
        push(2519, 2, RR, 5'h1F); push(2519, 2, GG, 6'h3F);
        push(2520, 2, DE, 1); push(2520, 2, RR, 0); push(2520, 2, GG, 0); push(2520, 2, BB, 0);
        push(2520, 2, PX, 32); push(2520, 2, PY, 32);
        wait_to(2530);
        @(negedge clk);

        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL dut%0d %s: check due at cycle %0d never reached", e.d, names[e.s], e.t);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
